// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
//   Shared types and default timing for the video timing generator.
//   - axis_state_t : per-axis segment state (SYNC -> BACK -> ACTIVE -> FRONT)
//   - DEF_*        : default 640x480@60 timing (800 x 525 totals)
// -----------------------------------------------------------------------------
package video_timing_pkg;

   typedef enum logic [1:0] {
      AX_SYNC   = 2'd0,
      AX_BACK   = 2'd1,
      AX_ACTIVE = 2'd2,
      AX_FRONT  = 2'd3
   } axis_state_t;

   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_CNT_W    = 12;

endpackage

// File: rtl/video_timing_axis.sv
// -----------------------------------------------------------------------------
// video_timing_axis
//   One timing axis: a position counter plus a SYNC/BACK/ACTIVE/FRONT state
//   register kept in lock-step with it. Instanced once per axis.
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   asynchronous active-low reset (count 0, state SYNC)
//   clear    in   synchronous clear to count 0 / SYNC, wins over advance
//   advance  in   step the counter by one position
//   count    out  current position, 0..TOTAL-1
//   state    out  segment the current position lies in
//   wrap     out  advance while on the last position (count returns to 0)
// -----------------------------------------------------------------------------
module video_timing_axis
   import video_timing_pkg::*;
#(
   parameter int SYNC   = 1,
   parameter int BACK   = 1,
   parameter int ACTIVE = 1,
   parameter int FRONT  = 1,
   parameter int CNT_W  = 12
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             advance,
   output logic [CNT_W-1:0] count,
   output axis_state_t      state,
   output logic             wrap
);

   localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;

   // Illegal timing is caught while elaborating rather than producing a
   // silently broken counter.
   if (SYNC < 1 || BACK < 1 || ACTIVE < 1 || FRONT < 1 || TOTAL > (2 ** CNT_W)) begin : g_bad_params
      $error("video_timing_axis: segment of zero length or total does not fit CNT_W");
   end

   // Last position of each segment; the state steps on the cycle that leaves it.
   localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(SYNC - 1);
   localparam logic [CNT_W-1:0] END_BACK   = CNT_W'(SYNC + BACK - 1);
   localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(SYNC + BACK + ACTIVE - 1);
   localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] count_q, count_d;
   axis_state_t      state_q, state_d;

   assign wrap  = advance && (count_q == END_FRONT);
   assign count = count_q;
   assign state = state_q;

   always_comb begin
      count_d = count_q;
      state_d = state_q;
      if (clear) begin
         count_d = '0;
         state_d = AX_SYNC;
      end else if (advance) begin
         count_d = wrap ? '0 : count_q + CNT_W'(1);
         unique case (state_q)
            AX_SYNC:   if (count_q == END_SYNC)   state_d = AX_BACK;
            AX_BACK:   if (count_q == END_BACK)   state_d = AX_ACTIVE;
            AX_ACTIVE: if (count_q == END_ACTIVE) state_d = AX_FRONT;
            AX_FRONT:  if (wrap)                  state_d = AX_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         state_q <= AX_SYNC;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/video_timing_generator.sv
// -----------------------------------------------------------------------------
// video_timing_generator
//   Parametrised raster timing: horizontal and vertical axis FSMs, sync
//   polarity, run/stop enable, line/frame start strobes. All outputs are
//   registered, so each output reflects the counters of the previous cycle.
//   in_reset_n is expected to be released synchronously to in_vga_clk by the
//   upstream reset conditioning.
// Build option
//   VIDEO_TIMING_COORD_EN : adds out_pixel_x / out_pixel_y (active-area
//                           coordinates, 0 outside the active area).
// Ports
//   in_vga_clk       in   pixel clock
//   in_reset_n       in   asynchronous active-low reset
//   in_enable        in   1 = run, 0 = hold at frame start with idle outputs
//   out_h_sync       out  horizontal sync, active level H_SYNC_POL
//   out_v_sync       out  vertical sync, active level V_SYNC_POL
//   out_blank_n      out  1 while both axes are in their active segment
//   out_line_start   out  strobe at h_count == 0
//   out_frame_start  out  strobe at h_count == 0 and v_count == 0
//   out_pixel_x/y    out  active-area column/row (VIDEO_TIMING_COORD_EN only)
// -----------------------------------------------------------------------------
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BACK     = DEF_H_BACK,
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FRONT    = DEF_H_FRONT,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BACK     = DEF_V_BACK,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FRONT    = DEF_V_FRONT,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             in_vga_clk,
   input  logic             in_reset_n,
   input  logic             in_enable,
   output logic             out_h_sync,
   output logic             out_v_sync,
   output logic             out_blank_n,
   output logic             out_line_start,
   output logic             out_frame_start
`ifdef VIDEO_TIMING_COORD_EN
   ,
   output logic [CNT_W-1:0] out_pixel_x,
   output logic [CNT_W-1:0] out_pixel_y
`endif
);

   logic [CNT_W-1:0] h_count, v_count;
   axis_state_t      h_state, v_state;
   logic             h_wrap;
   logic             v_wrap_unused;
   logic             clear;

   // Dropping enable forces both axes back to the frame origin, so a restart
   // never resumes a partial line.
   assign clear = !in_enable;

   video_timing_axis #(
      .SYNC   (H_SYNC),
      .BACK   (H_BACK),
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .CNT_W  (CNT_W)
   ) u_h_axis (
      .clk     (in_vga_clk),
      .reset_n (in_reset_n),
      .clear   (clear),
      .advance (1'b1),
      .count   (h_count),
      .state   (h_state),
      .wrap    (h_wrap)
   );

   video_timing_axis #(
      .SYNC   (V_SYNC),
      .BACK   (V_BACK),
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .CNT_W  (CNT_W)
   ) u_v_axis (
      .clk     (in_vga_clk),
      .reset_n (in_reset_n),
      .clear   (clear),
      .advance (h_wrap),
      .count   (v_count),
      .state   (v_state),
      .wrap    (v_wrap_unused)
   );

   logic h_sync_q, h_sync_d;
   logic v_sync_q, v_sync_d;
   logic blank_n_q, blank_n_d;
   logic line_start_q, line_start_d;
   logic frame_start_q, frame_start_d;
   logic active_area;

   assign active_area = (h_state == AX_ACTIVE) && (v_state == AX_ACTIVE);

   always_comb begin
      h_sync_d      = ~H_SYNC_POL;
      v_sync_d      = ~V_SYNC_POL;
      blank_n_d     = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (in_enable) begin
         h_sync_d      = (h_state == AX_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
         v_sync_d      = (v_state == AX_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
         blank_n_d     = active_area;
         line_start_d  = (h_count == '0);
         frame_start_d = (h_count == '0) && (v_count == '0);
      end
   end

   always_ff @(posedge in_vga_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         h_sync_q      <= ~H_SYNC_POL;
         v_sync_q      <= ~V_SYNC_POL;
         blank_n_q     <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         h_sync_q      <= h_sync_d;
         v_sync_q      <= v_sync_d;
         blank_n_q     <= blank_n_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign out_h_sync      = h_sync_q;
   assign out_v_sync      = v_sync_q;
   assign out_blank_n     = blank_n_q;
   assign out_line_start  = line_start_q;
   assign out_frame_start = frame_start_q;

`ifdef VIDEO_TIMING_COORD_EN
   localparam logic [CNT_W-1:0] X_ORIGIN = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] Y_ORIGIN = CNT_W'(V_SYNC + V_BACK);

   logic [CNT_W-1:0] pixel_x_q, pixel_x_d;
   logic [CNT_W-1:0] pixel_y_q, pixel_y_d;

   // Coordinates follow blank_n exactly: zero whenever the beam is outside
   // the active area or the generator is stopped.
   always_comb begin
      pixel_x_d = '0;
      pixel_y_d = '0;
      if (in_enable && active_area) begin
         pixel_x_d = h_count - X_ORIGIN;
         pixel_y_d = v_count - Y_ORIGIN;
      end
   end

   always_ff @(posedge in_vga_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         pixel_x_q <= '0;
         pixel_y_q <= '0;
      end else begin
         pixel_x_q <= pixel_x_d;
         pixel_y_q <= pixel_y_d;
      end
   end

   assign out_pixel_x = pixel_x_q;
   assign out_pixel_y = pixel_y_q;
`endif

endmodule

// File: tb/tb_video_timing_generator.sv
// -----------------------------------------------------------------------------
// tb_video_timing_generator
//   Small raster (H 2/2/4/2, V 1/1/2/1, 50-cycle frame) with active-high
//   h_sync and active-low v_sync. A reference model computes each cycle's
//   expected outputs from the segment boundaries, pushes them into a
//   scoreboard queue, and the checker pops and compares after the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_video_timing_generator;

   localparam int H_S = 2, H_B = 2, H_A = 4, H_F = 2;
   localparam int V_S = 1, V_B = 1, V_A = 2, V_F = 1;
   localparam int H_T = H_S + H_B + H_A + H_F;
   localparam int V_T = V_S + V_B + V_A + V_F;
   localparam bit H_POL = 1'b1;
   localparam bit V_POL = 1'b0;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic hs, vs, bl, ls, fs;
   logic [CW-1:0] px, py;

   always #5 clk = ~clk;

   video_timing_generator #(
      .H_SYNC (H_S), .H_BACK (H_B), .H_ACTIVE (H_A), .H_FRONT (H_F),
      .V_SYNC (V_S), .V_BACK (V_B), .V_ACTIVE (V_A), .V_FRONT (V_F),
      .H_SYNC_POL (H_POL), .V_SYNC_POL (V_POL), .CNT_W (CW)
   ) dut (
      .in_vga_clk      (clk),
      .in_reset_n      (rst_n),
      .in_enable       (en),
      .out_h_sync      (hs),
      .out_v_sync      (vs),
      .out_blank_n     (bl),
      .out_line_start  (ls),
      .out_frame_start (fs)
`ifdef VIDEO_TIMING_COORD_EN
      ,
      .out_pixel_x     (px),
      .out_pixel_y     (py)
`endif
   );

`ifndef VIDEO_TIMING_COORD_EN
   assign px = '0;
   assign py = '0;
`endif

   typedef struct packed {
      logic          hs, vs, bl, ls, fs;
      logic [CW-1:0] x, y;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   bit   measure  = 1'b0;
   bit   done     = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Reference model: expected outputs are derived from where (h, v) lies
   // relative to the segment boundaries, then the position advances.
   initial begin
      int   h = 0, v = 0;
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         e = '{hs: !H_POL, vs: !V_POL, bl: 1'b0, ls: 1'b0, fs: 1'b0, x: '0, y: '0};
         if (rst_n && en) begin
            e.hs = (h < H_S) ? H_POL : !H_POL;
            e.vs = (v < V_S) ? V_POL : !V_POL;
            e.bl = (h >= H_S + H_B) && (h < H_S + H_B + H_A) &&
                   (v >= V_S + V_B) && (v < V_S + V_B + V_A);
            e.ls = (h == 0);
            e.fs = (h == 0) && (v == 0);
            if (e.bl) begin
               e.x = CW'(h - (H_S + H_B));
               e.y = CW'(v - (V_S + V_B));
            end
            h++;
            if (h == H_T) begin
               h = 0;
               v++;
               if (v == V_T) v = 0;
            end
         end else begin
            h = 0;
            v = 0;
         end
         sb.push_back(e);
      end
   end

   // Checker: compares the DUT outputs 1 ns after each edge against the
   // scoreboard head; also measures frame/line periods in the free run.
   initial begin
      exp_t e;
      int   last_fs = -1, last_ls = -1;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("sync_blank_strobes", {27'd0, hs, vs, bl, ls, fs},
                      {27'd0, e.hs, e.vs, e.bl, e.ls, e.fs});
`ifdef VIDEO_TIMING_COORD_EN
            check_val("pixel_xy", {16'd0, px, py}, {16'd0, e.x, e.y});
`endif
         end
         if (measure) begin
            if (fs) begin
               if (last_fs >= 0) check_val("frame_period", 32'(cyc - last_fs), 32'(H_T * V_T));
               last_fs = cyc;
            end
            if (ls) begin
               if (last_ls >= 0) check_val("line_period", 32'(cyc - last_ls), 32'(H_T));
               last_ls = cyc;
            end
         end else begin
            last_fs = -1;
            last_ls = -1;
         end
      end
   end

   task automatic run_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_blank(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bl) found = 1'b1;
      end
      if (!found) check_val(tag, 32'd0, 32'd1);
   endtask

   initial begin
      // Reset and idle with enable low.
      $display("phase: reset, then idle with enable low");
      run_cycles(3);
      rst_n = 1'b1;
      run_cycles(3);

      // Free run: two full frames plus a partial one.
      $display("phase: run from frame origin, 120 cycles");
      en = 1'b1;
      run_cycles(120);

      // Asynchronous reset in the middle of an active line.
      $display("phase: async reset during active area");
      wait_blank("wait_blank_before_reset");
      #2 rst_n = 1'b0;
      #1;
      check_val("async_reset_outputs", {27'd0, hs, vs, bl, ls, fs},
                {27'd0, !H_POL, !V_POL, 3'b000});
      check_val("async_reset_xy", {16'd0, px, py}, 32'd0);
      run_cycles(2);
      rst_n = 1'b1;
      run_cycles(70);

      // Enable dropped mid-line for 10 cycles, then restarted.
      $display("phase: enable gap of 10 cycles mid-line");
      wait_blank("wait_blank_before_gap");
      en = 1'b0;
      run_cycles(10);
      en = 1'b1;
      @(posedge clk);
      #1;
      check_val("restart_strobes", {30'd0, fs, ls}, 32'd3);
      run_cycles(40);

      // Random enable pattern.
      $display("phase: random enable, 80 cycles");
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         en = ($urandom_range(0, 7) != 0);
      end

      // Clean restart and long free run with period measurement.
      $display("phase: free run with frame/line period measurement");
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      measure = 1'b1;
      run_cycles(4 * H_T * V_T + 5);
      measure = 1'b0;
      run_cycles(2);
      done = 1'b1;
   end

   initial begin
      wait (done);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
